// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync, debounce, 1-cycle press pulses and a CANCEL long-press
// master-reset request (rst_3). Define BTN_AUTOREPEAT_EN to build UP/DOWN auto-repeat.
module button_conditioner #(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 150_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       cancel_btn,
    input  logic       ok_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    output logic       mode_input,
    output logic       cancel_input,
    output logic       ok_input,
    output logic       up_input,
    output logic       down_input,
    output logic       rst_3,
    output logic [4:0] btn_level
);
    localparam int NB = 5;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    // Bit order everywhere: {mode, cancel, ok, up, down}
    logic [NB-1:0] raw, norm, sync1, sync2, level, level_q, rise, pulse_d, pulse;
    logic [DW-1:0] db_cnt [NB];

    assign raw  = {mode_btn, cancel_btn, ok_btn, up_btn, down_btn};
    assign norm = ACTIVE_LOW ? ~raw : raw;
    assign rise = level & ~level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= norm;
            sync2   <= sync1;
            level_q <= level;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_RATE  = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] R_MAX   = RW'(RMAX);

    // rep_cnt counts cycles since the last UP/DOWN pulse; rep_first selects the initial delay
    logic [RW-1:0] rep_cnt [2];
    logic [1:0]    rep_first, rep_fire;

    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 2; i++)
            rep_fire[i] = level[i] && level_q[i] &&
                          (rep_cnt[i] == (rep_first[i] ? R_DELAY : R_RATE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_first <= '1;
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rise[i]) begin
                    rep_cnt[i]   <= RW'(1);
                    rep_first[i] <= 1'b1;
                end else if (level[i] && level_q[i]) begin
                    if (rep_fire[i]) begin
                        rep_cnt[i]   <= RW'(1);
                        rep_first[i] <= 1'b0;
                    end else if (rep_cnt[i] != R_MAX) begin
                        rep_cnt[i] <= rep_cnt[i] + 1'b1;
                    end
                end else begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        pulse_d      = rise;
        pulse_d[1:0] = rise[1:0] | rep_fire;
    end
`else
    always_comb pulse_d = rise;
`endif

    // CANCEL hold FSM
    typedef enum logic [1:0] {IDLE, COUNT, FIRED} hold_state_t;
    hold_state_t   state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          cancel_lvl, fire;

    assign cancel_lvl = level[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cancel_lvl) state_nxt = COUNT;
            COUNT:   if (!cancel_lvl) state_nxt = IDLE;
                     else if (hold_cnt == HOLD_LAST) state_nxt = FIRED;
            FIRED:   if (!cancel_lvl) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb fire = (state == COUNT) && cancel_lvl && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           hold_cnt <= '0;
        else if (state == IDLE)                            hold_cnt <= '0;
        else if (state == COUNT && hold_cnt != HOLD_LAST)  hold_cnt <= hold_cnt + 1'b1;
    end

    // All outputs registered so they are glitch-free toward the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse <= '0;
            rst_3 <= 1'b0;
        end else begin
            pulse <= pulse_d;
            rst_3 <= fire;
        end
    end

    assign mode_input   = pulse[4];
    assign cancel_input = pulse[3];
    assign ok_input     = pulse[2];
    assign up_input     = pulse[1];
    assign down_input   = pulse[0];
    assign btn_level    = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity checked
// every cycle against an event-timing reference model.
module tb_button_conditioner;
    localparam int D  = 4;
    localparam int H  = 20;
    localparam int RD = 10;
    localparam int RR = 5;

    logic clk = 1'b0;
    logic rst;
    logic mode_btn, cancel_btn, ok_btn, up_btn, down_btn;
    logic mode_input, cancel_input, ok_input, up_input, down_input, rst_3;
    logic [4:0] btn_level;

    button_conditioner #(
        .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst),
        .mode_btn(mode_btn), .cancel_btn(cancel_btn), .ok_btn(ok_btn),
        .up_btn(up_btn), .down_btn(down_btn),
        .mode_input(mode_input), .cancel_input(cancel_input), .ok_input(ok_input),
        .up_input(up_input), .down_input(down_input),
        .rst_3(rst_3), .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: level flips once the last D+1 synced samples all disagree with it;
    // the pulse follows one edge after the flip; rst_3 lands H edges after the CANCEL pulse.
    logic [4:0] hist [$];
    logic [4:0] m_lvl, m_rise, exp_p;
    logic       exp_r;
    bit         armed;
    int         fire_at;
    bit [1:0]   rep_held;
    int         rep_at [2];

    // Observed event bookkeeping for directed checks
    int mode_n, cancel_n, ok_n, up_n, rst3_n;
    int cancel_at, ok_at, up_at, rst3_at;
    int up_times [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int k = 0; k < D + 3; k++) hist.push_back(5'b0);
        m_lvl = '0; m_rise = '0; exp_p = '0; exp_r = 1'b0;
        armed = 0; rep_held = '0;
    endtask

    task automatic model_edge(input logic [4:0] s);
        logic [4:0] old;
        bit flip;
        exp_p = m_rise;
        exp_r = 1'b0;
        if (armed && cyc == fire_at && m_lvl[3]) begin
            exp_r = 1'b1;
            armed = 0;
        end
`ifdef BTN_AUTOREPEAT_EN
        for (int b = 0; b < 2; b++)
            if (rep_held[b] && cyc == rep_at[b] && m_lvl[b]) begin
                exp_p[b]  = 1'b1;
                rep_at[b] = rep_at[b] + RR;
            end
        for (int b = 0; b < 2; b++)
            if (m_rise[b]) begin
                rep_held[b] = 1;
                rep_at[b]   = cyc + RD;
            end
`endif
        if (m_rise[3]) begin
            armed   = 1;
            fire_at = cyc + H;
        end
        hist.push_back(s);
        void'(hist.pop_front());
        old = m_lvl;
        for (int b = 0; b < 5; b++) begin
            flip = 1;
            for (int k = 0; k <= D; k++)
                if (hist[k][b] == m_lvl[b]) flip = 0;
            if (flip) m_lvl[b] = ~m_lvl[b];
        end
        m_rise = m_lvl & ~old;
        if (!m_lvl[3]) armed = 0;
        for (int b = 0; b < 2; b++)
            if (!m_lvl[b]) rep_held[b] = 0;
    endtask

    task automatic step(input string tag);
        logic [4:0] s;
        @(posedge clk);
        cyc++;
        s = ~{mode_btn, cancel_btn, ok_btn, up_btn, down_btn};
        if (rst) model_reset();
        else     model_edge(s);
        #1;
        check(tag, {21'b0, mode_input, cancel_input, ok_input, up_input, down_input, rst_3, btn_level},
                   {21'b0, exp_p, exp_r, m_lvl});
        if (mode_input)   mode_n++;
        if (cancel_input) begin cancel_n++; cancel_at = cyc; end
        if (ok_input)     begin ok_n++;     ok_at = cyc; end
        if (up_input)     begin up_n++;     up_at = cyc; up_times.push_back(cyc); end
        if (rst_3)        begin rst3_n++;   rst3_at = cyc; end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic clear_counts();
        mode_n = 0; cancel_n = 0; ok_n = 0; up_n = 0; rst3_n = 0;
        cancel_at = -1; ok_at = -1; up_at = -1; rst3_at = -1;
        up_times = {};
    endtask

    initial begin
        int t0;
        logic [4:0] b;
        rst = 1'b1;
        {mode_btn, cancel_btn, ok_btn, up_btn, down_btn} = 5'b11111;
        model_reset();
        run(3, "reset");
        check("reset_outputs", {26'b0, mode_input, cancel_input, ok_input, up_input, down_input, rst_3},
              32'd0);
        rst = 1'b0;
        run(5, "idle");

        // 1: single OK press, latency D+3 from first low sample
        clear_counts();
        ok_btn = 1'b0; t0 = cyc + 1;
        run(30, "ok_press");
        check("ok_pulse_count", ok_n, 1);
        check("ok_latency", ok_at - t0, 7);
        check("ok_level", btn_level[2], 1'b1);
        ok_btn = 1'b1;
        run(12, "ok_release");
        check("ok_no_release_pulse", ok_n, 1);

        // 2: MODE glitch shorter than debounce
        clear_counts();
        mode_btn = 1'b0;
        run(2, "mode_glitch");
        mode_btn = 1'b1;
        run(10, "mode_glitch");
        check("glitch_no_pulse", mode_n, 0);
        check("glitch_level", btn_level, 5'b0);

        // 3: CANCEL long press fires rst_3 once
        clear_counts();
        cancel_btn = 1'b0;
        run(40, "cancel_hold");
        check("cancel_pulse_count", cancel_n, 1);
        check("rst3_count", rst3_n, 1);
        check("rst3_delay", rst3_at - cancel_at, H);
        cancel_btn = 1'b1;
        run(12, "cancel_release");

        // 4: simultaneous OK and UP
        clear_counts();
        ok_btn = 1'b0; up_btn = 1'b0;
        run(12, "simul");
        check("simul_ok", ok_n, 1);
        check("simul_same_cycle", ok_at, up_at);
        ok_btn = 1'b1; up_btn = 1'b1;
        run(12, "simul_release");

        // 5: reset in the middle of a CANCEL hold
        clear_counts();
        cancel_btn = 1'b0;
        run(18, "cancel_pre_rst");
        rst = 1'b1;
        #1;
        check("rst_immediate", {20'b0, mode_input, cancel_input, ok_input, up_input, down_input,
                                rst_3, btn_level}, 32'd0);
        step("rst_pulse");
        rst = 1'b0;
        clear_counts();
        t0 = cyc + 1;
        run(30, "cancel_post_rst");
        check("post_rst_cancel_latency", cancel_at - t0, 7);
        check("post_rst_rst3_delay", rst3_at - cancel_at, H);
        check("post_rst_rst3_count", rst3_n, 1);
        cancel_btn = 1'b1;
        run(12, "cancel_release2");

        // 6: UP held 30 cycles
        clear_counts();
        up_btn = 1'b0; t0 = cyc + 1;
        run(30, "up_hold");
        up_btn = 1'b1;
        run(12, "up_release");
`ifdef BTN_AUTOREPEAT_EN
        check("up_repeat_count", up_n, 5);
        if (up_times.size() == 5) begin
            check("up_first", up_times[0] - t0, 7);
            check("up_rep1", up_times[1] - up_times[0], 10);
            check("up_rep2", up_times[2] - up_times[0], 15);
            check("up_rep3", up_times[3] - up_times[0], 20);
            check("up_rep4", up_times[4] - up_times[0], 25);
        end
`else
        check("up_single_pulse", up_n, 1);
        check("up_first", up_at - t0, 7);
`endif

        // Random activity on all buttons with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(599) == 0) rst = 1'b1;
            b = {mode_btn, cancel_btn, ok_btn, up_btn, down_btn};
            for (int k = 0; k < 5; k++)
                if ($urandom_range((k == 3) ? 29 : 7) == 0) b[k] = ~b[k];
            {mode_btn, cancel_btn, ok_btn, up_btn, down_btn} = b;
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
